seq_detect_param: RTL
=====================

# seq_detect_param

Parametrised, runtime-configurable serial sequence detector, the successor to the fixed-pattern `seq_rtl` FSM. It samples one bit per qualified clock and compares the most recent `pat_len` bits against a programmable pattern. It supports overlapping and non-overlapping detection and keeps a saturating match counter. It sits on the serial ingress path and feeds detection pulses and counts to control logic.

## Interface
- `PAT_W`, 8: maximum pattern length in bits (≥2).
- `CNT_W`, 16: match counter width.
- `RST_PATTERN`, 8'b0000_1011: pattern after reset. The reset length is `RST_LEN`.
- `RST_LEN`, 4: pattern length after reset (1..PAT_W).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_load`  in  1  strobe: latch `cfg_pattern`, `cfg_len`, `cfg_overlap`; flush history.
- `cfg_pattern`  in  PAT_W  pattern. Bit `[len-1]` is the first bit received and bit `[0]` is the last.
- `cfg_len`  in  $clog2(PAT_W+1)  pattern length.
- `cfg_overlap`  in  1  1 = overlapping detection, 0 = non-overlapping.
- `in_valid`  in  1  `serial_in` is sampled only when high.
- `serial_in`  in  1  serial data, MSB-first.
- `cnt_clr`  in  1  synchronous clear of `match_count`.
- `detected`  out  1  registered one-cycle match pulse.
- `match_count`  out  CNT_W  saturating number of matches.
- `armed`  out  1  history holds ≥ len valid bits (state S_ARMED).

## Operation
- Active config registers are `pat_q`, `len_q`, `ovl_q`. Reset values: `RST_PATTERN`, `RST_LEN`, 1.
- `cfg_len` clamping when latched: 0 latches as 1; values > PAT_W latch as PAT_W.
- History is a PAT_W-bit shift register `hist_q` with a fill counter `fill_q` (0..len_q).
- Each accepted bit (`in_valid`=1, `cfg_load`=0) shifts in at LSB: `hist <= {hist[PAT_W-2:0], serial_in}`. `fill_q` increments and saturates at `len_q`.
- The match condition is evaluated on the post-shift history: `(hist_next & mask) == (pat_q & mask)` and `fill_next == len_q`, where mask = low `len_q` bits set.
- FSM states:
  - S_FILL: `fill_q` < `len_q`. Moves to S_ARMED when `fill_q` reaches `len_q`.
  - S_ARMED: compare is active. On a match with `ovl_q`=0, `fill_q` returns to 0 and the state goes to S_FILL. On a match with `ovl_q`=1, it stays in S_ARMED.
- `cfg_load`=1: latch config, clear `hist_q` and `fill_q`, go to S_FILL, force `detected` to 0 next cycle. The same-cycle `serial_in` is discarded. `match_count` is unaffected.
- `in_valid`=0: history, fill and state hold, and `detected` goes to 0.
- Counter: a match increments `match_count`. It saturates at 2^CNT_W−1 and does not wrap.
- `cnt_clr` together with a match in the same cycle: the clear wins, so the count becomes 0, but `detected` still pulses.
- Reset values: `detected`=0, `match_count`=0, `armed`=0, state S_FILL, `hist_q`=0, `fill_q`=0.

## Timing
- A bit is sampled at rising edge N. `detected` is high during cycle N→N+1 only, and `match_count` updates at the same edge N. Latency is 1 clock from the sampling edge.
- Back-to-back matches in overlap mode produce consecutive `detected` pulses. With `len_q`=1 there can be a pulse on every accepted bit.
- `armed` is registered and reflects state after edge N.
- Asserting `rst` mid-stream immediately clears all outputs and history. The config returns to the `RST_*` values.
- `cfg_load` takes effect at the edge where it is sampled. The first bit of the new config is the next accepted bit.

## Structure
- Package `seq_detect_pkg`:
  - state enum {S_FILL, S_ARMED}
  - `LEN_W = $clog2(PAT_W+1)` helper
  - the mask-generation function
- Sub-module `seq_match_cmp`: combinational masked comparator (history, pattern, len → match). This lets the compare be reused by a later multi-channel version.

## Test plan
- Reset config (1011, len 4, overlap), stream `1011011` → `detected` pulses after the 4th and 7th bits, `match_count`=2.
- `cfg_load` with 1011 / len 4 / overlap=0, same stream → single pulse after the 4th bit, `match_count`=1, `armed`=0 after the pulse.
- Stream `1,0,(in_valid=0 for 3 cycles),1,1` → exactly one pulse, one cycle after the final bit. No pulse during the gap.
- `cfg_len`=0 with pattern bit0=1, stream `1,1,0,1` → 3 pulses. `cfg_len`=15 with PAT_W=8 behaves as len 8.
- CNT_W=4, 20 overlapping len-1 matches → `match_count` holds at 15. `cnt_clr` coinciding with a match → count 0, `detected`=1.
- Assert `rst` during a partial match (`101` received), then send `1` after release → no pulse, all outputs 0 during reset.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the parametrised serial sequence detector.
package seq_detect_pkg;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_e;

    // Widest pattern the mask helper can describe; instances slice it down.
    localparam int unsigned MASK_MAX_W = 64;

    function automatic int unsigned len_w(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Low `len` bits set, the rest clear.
    function automatic logic [MASK_MAX_W-1:0] len_mask(input int unsigned len);
        logic [MASK_MAX_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MASK_MAX_W; i++) begin
            if (i < len) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_detect_param_cmp.sv
// Combinational masked comparator: history equals pattern over the low len bits.
module seq_match_cmp
    import seq_detect_pkg::*;
#(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = len_w(PAT_W)
) (
    input  logic [PAT_W-1:0] hist,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             match_c
);

    logic [PAT_W-1:0] mask;

    assign mask    = PAT_W'(len_mask(32'(len)));
    assign match_c = (((hist ^ pattern) & mask) == '0);

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-configurable serial sequence detector with overlap control and a
// saturating match counter.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int unsigned            PAT_W       = 8,
    parameter int unsigned            CNT_W       = 16,
    parameter logic [PAT_W-1:0]       RST_PATTERN = PAT_W'(8'b0000_1011),
    parameter int unsigned            RST_LEN     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_load,
    input  logic [PAT_W-1:0]              cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0]    cfg_len,
    input  logic                          cfg_overlap,
    input  logic                          in_valid,
    input  logic                          serial_in,
    input  logic                          cnt_clr,
    output logic                          detected,
    output logic [CNT_W-1:0]              match_count,
    output logic                          armed
);

    localparam int unsigned       LEN_W     = len_w(PAT_W);
    localparam logic [LEN_W-1:0]  RST_LEN_L = LEN_W'(RST_LEN);
    localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;

    logic               detected_d;
    logic [CNT_W-1:0]   count_d;
    logic               armed_d;

    logic               accept_c;
    logic [PAT_W-1:0]   hist_shift_c;
    logic [LEN_W-1:0]   fill_inc_c;
    logic [LEN_W-1:0]   cfg_len_clamp_c;
    logic               cmp_c;
    logic               match_c;

    // Candidate history/fill as if the current bit were accepted.
    assign accept_c     = in_valid & ~cfg_load;
    assign hist_shift_c = {hist_q[PAT_W-2:0], serial_in};
    assign fill_inc_c   = (fill_q < len_q) ? (fill_q + LEN_W'(1)) : len_q;

    seq_match_cmp #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_cmp (
        .hist    (hist_shift_c),
        .pattern (pat_q),
        .len     (len_q),
        .match_c (cmp_c)
    );

    assign match_c = accept_c & cmp_c & (fill_inc_c == len_q);

    always_comb begin
        cfg_len_clamp_c = cfg_len;
        if (cfg_len == '0) begin
            cfg_len_clamp_c = LEN_W'(1);
        end else if (cfg_len > MAX_LEN_L) begin
            cfg_len_clamp_c = MAX_LEN_L;
        end
    end

    // State and configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FILL;
            pat_q       <= RST_PATTERN;
            len_q       <= RST_LEN_L;
            ovl_q       <= 1'b1;
            hist_q      <= '0;
            fill_q      <= '0;
            detected    <= 1'b0;
            match_count <= '0;
            armed       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            ovl_q       <= ovl_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            detected    <= detected_d;
            match_count <= count_d;
            armed       <= armed_d;
        end
    end

    // Next state, history and configuration.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;

        if (cfg_load) begin
            pat_d   = cfg_pattern;
            len_d   = cfg_len_clamp_c;
            ovl_d   = cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = S_FILL;
        end else if (in_valid) begin
            hist_d = hist_shift_c;
            if (match_c && !ovl_q) begin
                // Non-overlapping: the matched bits are consumed.
                fill_d  = '0;
                state_d = S_FILL;
            end else begin
                fill_d  = fill_inc_c;
                state_d = (fill_inc_c == len_q) ? S_ARMED : S_FILL;
            end
        end
    end

    // Registered outputs; clear wins over a same-cycle increment.
    always_comb begin
        detected_d = match_c;
        armed_d    = (state_d == S_ARMED);
        count_d    = match_count;
        if (cnt_clr) begin
            count_d = '0;
        end else if (match_c && (match_count != CNT_MAX)) begin
            count_d = match_count + CNT_W'(1);
        end
    end

endmodule
